// File: rtl/dsp_regfile_writeback.sv
// Register file and write-back stage for the DSP pipeline.
// A one-entry commit latch holds each write-back for one cycle before it lands in the array.
// Both read ports bypass from the incoming write (youngest) and from the latch.
// Register 0 is hard-wired to zero.
module dsp_regfile_writeback #(
  parameter int unsigned REG_WORD_LEN = 16,
  parameter int unsigned NUM_REGS     = 16,
  parameter int unsigned REG_ADDR_LEN = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wb_valid,
  input  logic [REG_ADDR_LEN-1:0] wb_addr,
  input  logic [REG_WORD_LEN-1:0] wb_data,
  input  logic                    mem_is_load,
  input  logic [REG_ADDR_LEN-1:0] rd_addr_s1,
  input  logic [REG_ADDR_LEN-1:0] rd_addr_s2,
  output logic [REG_WORD_LEN-1:0] rd_data_s1,
  output logic [REG_WORD_LEN-1:0] rd_data_s2,
  output logic                    hazard_stall,
  output logic [15:0]             commit_count
);

  logic [REG_WORD_LEN-1:0] regs_q [NUM_REGS];
  logic                    valid_q;
  logic [REG_ADDR_LEN-1:0] addr_q;
  logic [REG_WORD_LEN-1:0] data_q;
  logic [15:0]             commit_count_q;
  logic                    wb_live;

  // Writes to register 0 are discarded before they reach the latch.
  assign wb_live = wb_valid && (wb_addr != '0);

  // Commit latch, register array and commit counter; reset drops any in-flight entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      valid_q        <= 1'b0;
      addr_q         <= '0;
      data_q         <= '0;
      commit_count_q <= '0;
    end else begin
      valid_q <= wb_live;
      addr_q  <= wb_addr;
      data_q  <= wb_data;
      // valid_q implies addr_q != 0, so register 0 is never written.
      if (valid_q) begin
        regs_q[addr_q] <= data_q;
        commit_count_q <= commit_count_q + 16'd1;
      end
    end
  end

  // Operand 1 read: zero register, then incoming write, then latch, then array.
  always_comb begin
    rd_data_s1 = regs_q[rd_addr_s1];
    if (rd_addr_s1 == '0) begin
      rd_data_s1 = '0;
    end else if (wb_live && (wb_addr == rd_addr_s1)) begin
      rd_data_s1 = wb_data;
    end else if (valid_q && (addr_q == rd_addr_s1)) begin
      rd_data_s1 = data_q;
    end
  end

  // Operand 2 read: same priority as operand 1.
  always_comb begin
    rd_data_s2 = regs_q[rd_addr_s2];
    if (rd_addr_s2 == '0) begin
      rd_data_s2 = '0;
    end else if (wb_live && (wb_addr == rd_addr_s2)) begin
      rd_data_s2 = wb_data;
    end else if (valid_q && (addr_q == rd_addr_s2)) begin
      rd_data_s2 = data_q;
    end
  end

  // Load-use hazard: decode needs a register that the load in the memory stage is producing.
  always_comb begin
    hazard_stall = !rst && mem_is_load && wb_live &&
                   ((wb_addr == rd_addr_s1) || (wb_addr == rd_addr_s2));
  end

  assign commit_count = commit_count_q;

endmodule
